instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Fetch-side initiator for instructionMemory: owns the program counter, drives the PC
//   address each cycle, captures the combinational instruction word and presents
//   {pc, instr} pairs to decode over a valid/ready handshake. A 2-entry buffer decouples
//   decode stalls from fetch. Branch/jump redirects flush the buffer and restart fetch.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   BUF_DEPTH  2              fetch buffer entries (power of two, >=2)
// PORTS
//   clk             in   1   system clock, all state on rising edge
//   rst_n           in   1   asynchronous active-low reset
//   imemAddr        out  32  byte address to instructionMemory PC input
//   imemData        in   32  instruction word for imemAddr, valid same cycle (combinational)
//   redirectValid   in   1   take redirectPC this cycle (branch/jump resolved)
//   redirectPC      in   32  redirect target byte address
//   fetchValid      out  1   fetchInstr/fetchPC hold a valid instruction
//   fetchReady      in   1   decode accepts the head entry when fetchValid & fetchReady
//   fetchInstr      out  32  instruction at buffer head
//   fetchPC         out  32  byte address of fetchInstr
//   fetchMisalign   out  1   only with FETCH_MISALIGN_EN: misaligned redirect trap
// BEHAVIOUR
//   - Reset (async assert): pc=RESET_PC, buffer empty, fetchValid=0, fetchInstr=0,
//     fetchPC=0, fetchMisalign=0, state RUN. Outputs of an empty buffer read 0.
//   - imemAddr = pc at all times (combinational from pc register).
//   - Push: in RUN, no redirect, and (buffer not full OR pop this cycle) -> write
//     {pc, imemData} at tail, pc <= pc+4. Otherwise pc holds.
//   - Pop: fetchValid & fetchReady -> head advances. Push+pop same cycle when full is legal.
//   - fetchValid = buffer non-empty; head fields stable while fetchValid & !fetchReady.
//   - Latency: word at pc visible at outputs the cycle after the push edge; first
//     instruction after reset release valid after first clk edge.
//   - Sustained throughput 1 instr/cycle with fetchReady held high.
//   - Redirect: highest priority over push/pop. Buffer flushed (count=0), pc<=redirectPC,
//     no push that cycle; an accepted pop that cycle is discarded by the flush.
//     Target instruction valid the cycle after the following edge (1 bubble).
//   - PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//   - States: RUN (normal); HALT (only with FETCH_MISALIGN_EN). No other states.
//   - Reset mid-operation: immediate return to reset values; partial pushes discarded.
// CONFIGURATION
//   FETCH_MISALIGN_EN defined: redirect with redirectPC[1:0]!=0 flushes buffer, enters
//     HALT, fetchMisalign=1, no pushes; pc holds the misaligned target. HALT exits only on
//     an aligned redirect (-> RUN, fetchMisalign=0) or reset.
//   Undefined: redirectPC[1:0] forced to 2'b00; no HALT state; fetchMisalign port absent.
// STRUCTURE
//   fetch_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;
//     localparam INSTR_BYTES=4; localparam NOP_INSTR=32'h0000_0013; fetch_state_e {RUN,HALT}.
//   Sub-module fetch_buffer: BUF_DEPTH-entry FIFO of fetch_entry_t with push/pop/flush,
//     full/empty, registered pointers and count; instruction_fetch holds pc + state only.
// TESTING (bench instantiates instructionMemory and connects imemAddr/imemData)
//   1 mem[0..3]=00500113,00300193,003100b3,40310133, fetchReady=1 after reset ->
//     fetchPC 0,4,8,C on consecutive cycles with matching fetchInstr, no bubbles.
//   2 fetchReady=0 for 5 cycles from reset -> buffer fills at 2, pc stops at 8,
//     head stays PC=0/00500113; release -> 0,4,8 delivered in order, none lost or duplicated.
//   3 redirectValid with redirectPC=8 while buffer full -> next cycle fetchValid=0,
//     then fetchPC=8/003100b3, then C/40310133.
//   4 redirectPC=32'hFFFF_FFFC, fetchReady=1 -> fetchPC FFFF_FFFC then 0000_0000.
//   5 rst_n low mid-stream (not on clk edge) -> outputs 0, fetchValid=0 immediately;
//     after release restarts at RESET_PC.
//   6 FETCH_MISALIGN_EN: redirectPC=32'h6 -> fetchMisalign=1, fetchValid stays 0;
//     redirectPC=4 -> fetchMisalign=0, fetchPC=4/00300193. Undefined: 32'h6 fetches from 4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
package fetch_pkg;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   // One buffered fetch result: byte address plus the word read from it.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // HALT is reachable only when FETCH_MISALIGN_EN is defined.
   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // Sequential PC step; wraps modulo 2^32 with no flag.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: imem address/data, redirect request and decode handshake.
// Latency: none (wires only).
// Backpressure: fetchReady from decode; fetchMisalign exists only with FETCH_MISALIGN_EN.
interface instruction_fetch_if;

   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        fetchValid;
   logic        fetchReady;
   logic [31:0] fetchInstr;
   logic [31:0] fetchPC;
`ifdef FETCH_MISALIGN_EN
   logic        fetchMisalign;

   modport master (
      output imemAddr,
      input  imemData,
      input  redirectValid,
      input  redirectPC,
      output fetchValid,
      input  fetchReady,
      output fetchInstr,
      output fetchPC,
      output fetchMisalign
   );

   modport slave (
      input  imemAddr,
      output imemData,
      output redirectValid,
      output redirectPC,
      input  fetchValid,
      output fetchReady,
      input  fetchInstr,
      input  fetchPC,
      input  fetchMisalign
   );
`else
   modport master (
      output imemAddr,
      input  imemData,
      input  redirectValid,
      input  redirectPC,
      output fetchValid,
      input  fetchReady,
      output fetchInstr,
      output fetchPC
   );

   modport slave (
      input  imemAddr,
      output imemData,
      output redirectValid,
      output redirectPC,
      input  fetchValid,
      output fetchReady,
      input  fetchInstr,
      input  fetchPC
   );
`endif

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full_o when DEPTH entries held; push with pop while full is accepted.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW:0]   cnt_q, cnt_d;

   // Pointer and count update; flush wins over any push or pop in the same cycle.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + PW'(1);
         if (pop_i)  rd_d = rd_q + PW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer/count registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_q];
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, drives imemAddr and queues {pc, instr} pairs for decode.
// Latency: word at pc visible on fetch outputs the cycle after its push edge; a redirect costs one bubble.
// Backpressure: fetchReady low fills the buffer, after which pc holds until a pop frees an entry.
// Optional FETCH_MISALIGN_EN: misaligned redirect traps into HALT and raises fetchMisalign.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   instruction_fetch_if.master fif
);

   logic [31:0]  pc_q, pc_d;
   fetch_state_e state_q, state_d;
   logic [31:0]  redir_pc;
   logic         buf_push, buf_pop, buf_flush;
   logic         buf_full, buf_empty;
   fetch_entry_t buf_wdata, buf_head;

`ifdef FETCH_MISALIGN_EN
   logic redir_misalign;
   assign redir_pc       = fif.redirectPC;
   assign redir_misalign = |fif.redirectPC[1:0];
`else
   // Without the trap the target is simply word-aligned.
   logic [1:0] redir_lsb_unused;
   assign redir_pc         = {fif.redirectPC[31:2], 2'b00};
   assign redir_lsb_unused = fif.redirectPC[1:0];
`endif

   assign buf_pop   = !buf_empty && fif.fetchReady;
   assign buf_wdata = '{pc: pc_q, instr: fif.imemData};

   // Next PC/state: redirect first, otherwise fetch sequentially while a slot is free.
   always_comb begin
      pc_d      = pc_q;
      state_d   = state_q;
      buf_push  = 1'b0;
      buf_flush = 1'b0;
      if (fif.redirectValid) begin
         buf_flush = 1'b1;
         pc_d      = redir_pc;
`ifdef FETCH_MISALIGN_EN
         state_d   = redir_misalign ? HALT : RUN;
`else
         state_d   = RUN;
`endif
      end else if (state_q == RUN && (!buf_full || buf_pop)) begin
         buf_push = 1'b1;
         pc_d     = next_pc(pc_q);
      end
   end

   // PC and fetch state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (buf_push),
      .pop_i   (buf_pop),
      .flush_i (buf_flush),
      .wdata_i (buf_wdata),
      .rdata_o (buf_head),
      .full_o  (buf_full),
      .empty_o (buf_empty)
   );

   assign fif.imemAddr   = pc_q;
   assign fif.fetchValid = !buf_empty;
   // An empty buffer reads as zero rather than stale storage.
   assign fif.fetchPC    = buf_empty ? 32'h0 : buf_head.pc;
   assign fif.fetchInstr = buf_empty ? 32'h0 : buf_head.instr;
`ifdef FETCH_MISALIGN_EN
   assign fif.fetchMisalign = (state_q == HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle checks plus a scoreboard of expected {pc, instr}.
// The memory model is an array; expected streams are sequential PCs from the last redirect.
// FETCH_MISALIGN_EN selects the trap variant of the misaligned-redirect test.
module tb_instruction_fetch;
   import fetch_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instruction_fetch_if fif ();

   instruction_fetch #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fif   (fif)
   );

   int errors = 0;
   int checks = 0;
   int hits   = 0;

   logic [31:0] mem [0:63];

   // Instruction memory: array for the low 256 bytes, address-derived words elsewhere.
   assign fif.imemData = (fif.imemAddr < 32'd256) ? mem[fif.imemAddr[7:2]]
                                                  : (fif.imemAddr ^ 32'h5A5A_0F0F);

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd256) return mem[a[7:2]];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard of accepted fetches still expected from the current stream.
   fetch_entry_t exp_q [$];
   logic [31:0]  sb_next;

   task automatic sb_extend(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{pc: sb_next, instr: mem_word(sb_next)});
         sb_next = sb_next + 32'd4;
      end
   endtask

   task automatic sb_restart(input logic [31:0] a, input int n);
      exp_q.delete();
      sb_next = a;
      sb_extend(n);
   endtask

   // Monitor: every accepted handshake not cancelled by a redirect must match the stream head.
   always @(negedge clk) begin
      if (rst_n && fif.fetchValid && fif.fetchReady && !fif.redirectValid) begin
         hits++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %h, no entry expected", fif.fetchPC);
         end else begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            check("sb_pc", fif.fetchPC, e.pc);
            check("sb_instr", fif.fetchInstr, e.instr);
         end
      end
   end

   // Redirect target as the DUT is expected to use it.
   function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_EN
      return t;
`else
      return {t[31:2], 2'b00};
`endif
   endfunction

   // Asserts reset away from a clock edge, checks outputs clear at once, releases on a negedge.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      fif.redirectValid = 1'b0;
      #1;
      check({tag, "_rst_valid"}, 32'(fif.fetchValid), 32'd0);
      check({tag, "_rst_pc"}, fif.fetchPC, 32'h0);
      check({tag, "_rst_instr"}, fif.fetchInstr, 32'h0);
      check({tag, "_rst_addr"}, fif.imemAddr, 32'h0);
`ifdef FETCH_MISALIGN_EN
      check({tag, "_rst_misalign"}, 32'(fif.fetchMisalign), 32'd0);
`endif
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb_restart(32'h0, 16);
   endtask

   // One-cycle redirect pulse driven just after a rising edge.
   task automatic redirect(input logic [31:0] t, input logic rdy);
      @(posedge clk);
      #1;
      fif.redirectValid = 1'b1;
      fif.redirectPC    = t;
      fif.fetchReady    = rdy;
      sb_restart(eff_target(t), 16);
      @(posedge clk);
      #1;
      fif.redirectValid = 1'b0;
   endtask

   initial begin
      int h0;
      mem[0] = 32'h0050_0113;
      mem[1] = 32'h0030_0193;
      mem[2] = 32'h0031_00b3;
      mem[3] = 32'h4031_0133;
      for (int i = 4; i < 64; i++) mem[i] = $urandom;
      fif.redirectValid = 1'b0;
      fif.redirectPC    = 32'h0;
      fif.fetchReady    = 1'b0;
      sb_next           = 32'h0;

      // 1: streaming from reset with no bubbles.
      fif.fetchReady = 1'b1;
      do_reset("t1");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_valid", 32'(fif.fetchValid), 32'd1);
         check("t1_pc", fif.fetchPC, 32'(i * 4));
         check("t1_instr", fif.fetchInstr, mem[i]);
      end

      // 2: decode stalled, buffer fills at two, pc parks at 8, then drains in order.
      fif.fetchReady = 1'b0;
      do_reset("t2");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_head_pc", fif.fetchPC, 32'h0);
         check("t2_head_instr", fif.fetchInstr, 32'h0050_0113);
      end
      check("t2_pc_parked", fif.imemAddr, 32'h8);
      h0 = hits;
      @(posedge clk);
      #1;
      fif.fetchReady = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("t2_drained", 32'(hits - h0), 32'd3);

      // 3: redirect to 8 while full; the same-cycle pop is discarded.
      fif.fetchReady = 1'b0;
      do_reset("t3");
      repeat (3) @(negedge clk);
      redirect(32'h8, 1'b1);
      @(negedge clk);
      check("t3_bubble", 32'(fif.fetchValid), 32'd0);
      @(negedge clk);
      check("t3_pc8", fif.fetchPC, 32'h8);
      check("t3_instr8", fif.fetchInstr, 32'h0031_00b3);
      @(negedge clk);
      check("t3_pcC", fif.fetchPC, 32'hC);
      check("t3_instrC", fif.fetchInstr, 32'h4031_0133);

      // 4: PC wraps past the top of the address space.
      redirect(32'hFFFF_FFFC, 1'b1);
      @(negedge clk);
      check("t4_bubble", 32'(fif.fetchValid), 32'd0);
      @(negedge clk);
      check("t4_pc_top", fif.fetchPC, 32'hFFFF_FFFC);
      check("t4_instr_top", fif.fetchInstr, mem_word(32'hFFFF_FFFC));
      @(negedge clk);
      check("t4_pc_wrap", fif.fetchPC, 32'h0);
      check("t4_instr_wrap", fif.fetchInstr, 32'h0050_0113);

      // 5: reset in the middle of a stream, then restart at the reset PC.
      repeat (3) @(negedge clk);
      check("t5_pre_valid", 32'(fif.fetchValid), 32'd1);
      do_reset("t5");
      @(negedge clk);
      check("t5_restart_pc", fif.fetchPC, 32'h0);
      check("t5_restart_valid", 32'(fif.fetchValid), 32'd1);

      // 6: misaligned redirect.
`ifdef FETCH_MISALIGN_EN
      redirect(32'h6, 1'b1);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_misalign", 32'(fif.fetchMisalign), 32'd1);
         check("t6_halt_valid", 32'(fif.fetchValid), 32'd0);
      end
      redirect(32'h4, 1'b1);
      @(negedge clk);
      check("t6_misalign_clr", 32'(fif.fetchMisalign), 32'd0);
      @(negedge clk);
`else
      redirect(32'h6, 1'b1);
      @(negedge clk);
      check("t6_bubble", 32'(fif.fetchValid), 32'd0);
      @(negedge clk);
`endif
      check("t6_pc4", fif.fetchPC, 32'h4);
      check("t6_instr4", fif.fetchInstr, 32'h0030_0193);

      // Random backpressure and redirects against the scoreboard.
      h0 = hits;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         fif.fetchReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 255));
`ifdef FETCH_MISALIGN_EN
            t[1:0] = 2'b00;
`endif
            fif.redirectValid = 1'b1;
            fif.redirectPC    = t;
            sb_restart(eff_target(t), 8);
         end else begin
            fif.redirectValid = 1'b0;
            if (exp_q.size() < 4) sb_extend(8);
         end
      end
      @(posedge clk);
      #1;
      fif.redirectValid = 1'b0;
      fif.fetchReady    = 1'b0;
      @(negedge clk);
      check("rand_progress", 32'(hits - h0 > 150), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop if the run somehow fails to reach its summary.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
